weight_stream_loader: RTL and testbench
=======================================

Name: weight_stream_loader

Overview:
- Transmitter side of the neuron weight/bias configuration port.
- Accepts a packed 32-bit word stream from the host/DMA and parses per-neuron blocks: header, weights, optional bias.
- Drives the shared weightValid/weightValue/biasValid/biasValue/config_layer_num/config_neuron_num bus that every neuron in every layer snoops.
- Sits between the host AXI-stream bridge and the layer array.

Parameters:
- maxWeight, 784, largest legal weight count per neuron; header counts above this are errors.
- cntWidth, 16, width of the header weight-count field and internal counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; begins a load session
- total_neurons  in  16  number of neuron blocks in the session; sampled on start
- s_data  in  32  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts s_data this cycle
- weightValid  out  1  weight beat to the neuron array
- weightValue  out  32  weight word
- biasValid  out  1  bias beat to the neuron array
- biasValue  out  32  bias word
- config_layer_num  out  32  target layer, zero-extended
- config_neuron_num  out  32  target neuron, zero-extended
- busy  out  1  session in progress
- done  out  1  one-cycle pulse when the session completes
- err  out  1  sticky header error, cleared by rst or start
- neurons_loaded  out  16  completed neuron blocks in the current session

Behaviour:
- Reset values:
  - s_ready, weightValid, biasValid, busy, done, err, neurons_loaded, weightValue, biasValue: 0.
  - config_layer_num and config_neuron_num: 32'hFFFF_FFFF, so no neuron matches.
- Handshake: a beat is accepted when s_valid & s_ready. The neuron side has no backpressure.
- Header word layout:
  - [31:24] layer
  - [23:16] neuron
  - [15:0] weight count N
- States:
  - IDLE: s_ready=0. start -> HDR, busy=1, neurons_loaded=0, err=0, latch total_neurons. If total_neurons==0, go to DONE instead.
  - HDR: s_ready=1. On accept:
    - Register layer/neuron onto the config outputs.
    - Load remaining=N.
    - If N==0 or N>maxWeight: err=1, go to IDLE, busy=0, no done.
    - Otherwise go to WGT.
  - WGT: s_ready=1. Each accept produces a weightValid pulse with weightValue=s_data on the next clock. When the last of N is accepted -> BIAS (or BLKEND when bias loading is compiled out).
  - BIAS: s_ready=1. On accept: biasValid=1 and biasValue=s_data next clock -> BLKEND.
  - BLKEND: s_ready=0, one cycle.
    - neurons_loaded+1.
    - If it now equals the latched total -> DONE, else -> HDR.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency: output beats are registered, exactly 1 cycle after the accepting edge. Gaps in s_valid produce matching gaps in weightValid.
- Config outputs change only on a header accept. They hold their value through the following weight/bias beats and after session end, and are never changed in the same cycle as a weightValid pulse for the previous neuron. This guarantees neurons see stable address qualifiers.
- A start pulse while busy is ignored.
- rst mid-session returns to IDLE with all outputs at reset values. Partially loaded neurons are recovered by the shared system rst, not by this block.
- weightValid and biasValid are never high in the same cycle.

Optional Feature:
- Macro BIAS_LOAD_EN.
- Defined: each neuron block carries one bias word after its weights; the BIAS state exists and biasValid/biasValue are driven.
- Undefined: there is no bias word; WGT goes directly to BLKEND; biasValid is tied 0 and biasValue is tied 0. Neurons use their hard-coded bias constants.

Test Plan:
- Basic load (BIAS_LOAD_EN): start with total_neurons=1; stream header 32'h0218_0003, weights 11,22,33, bias 32'h0000_FE10 with continuous valid. Required:
  - config_layer_num=2, config_neuron_num=24.
  - weightValid pulses on 3 consecutive cycles carrying 11, 22, 33.
  - Then biasValid with FE10.
  - done pulse 2 cycles after the bias accept; neurons_loaded=1.
- Throttled stream: same block with s_valid low every other cycle. Required: weightValid pulses spaced by idle cycles, values in order, and the config outputs never change mid-block.
- Multi-neuron: total_neurons=3, headers for layer 1, neurons 0..2, N=2 each. Required:
  - Config outputs switch only after the previous block's last beat.
  - done asserted once; neurons_loaded=3.
- Header error: header with N=0, then separately N=maxWeight+1. Required: err=1, busy=0, no weightValid, no done; the next start clears err.
- Reset mid-WGT: assert rst after 2 of 5 weights. Required:
  - Next cycle: weightValid=0, busy=0, s_ready=0, config outputs at 32'hFFFF_FFFF.
  - A subsequent full session completes normally.
- BIAS_LOAD_EN undefined: header N=2, two weights. Required: done follows without a bias word; biasValid stays 0 throughout.

Source files
------------

// File: rtl/weight_stream_loader.sv
// weight_stream_loader: transmitter side of the neuron weight/bias configuration port.
// Parses a packed 32-bit host stream into per-neuron blocks (header, weights, optional
// bias) and drives the shared weight/bias bus that every neuron snoops.
// Optional feature macro: BIAS_LOAD_EN (defined: each block carries one bias word).
module weight_stream_loader #(
  parameter int maxWeight = 784,
  parameter int cntWidth  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] total_neurons,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        weightValid,
  output logic [31:0] weightValue,
  output logic        biasValid,
  output logic [31:0] biasValue,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] neurons_loaded
);

  typedef enum logic [2:0] {IDLE, HDR, WGT, BIAS, BLKEND, DONE} state_t;

  state_t              state;
  logic [cntWidth-1:0] remaining;
  logic [15:0]         total_lat;
  logic                accept;

  // A header weight count of zero or beyond the largest legal neuron fan-in is rejected.
  function automatic logic hdr_bad(input logic [cntWidth-1:0] n);
    return (n == '0) || (int'(n) > maxWeight);
  endfunction

  assign s_ready = (state == HDR) || (state == WGT) || (state == BIAS);
  assign accept  = s_valid && s_ready;

  // Session FSM with registered bus outputs; every neuron-side beat lands one clock after its accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      neurons_loaded    <= '0;
      weightValid       <= 1'b0;
      weightValue       <= '0;
      config_layer_num  <= '1;
      config_neuron_num <= '1;
      remaining         <= '0;
      total_lat         <= '0;
`ifdef BIAS_LOAD_EN
      biasValid         <= 1'b0;
      biasValue         <= '0;
`endif
    end else begin
      weightValid <= 1'b0;
      done        <= 1'b0;
`ifdef BIAS_LOAD_EN
      biasValid   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            neurons_loaded <= '0;
            err            <= 1'b0;
            total_lat      <= total_neurons;
            if (total_neurons == '0) begin
              // Empty session: report completion straight away.
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= HDR;
            end
          end
        end
        HDR: begin
          if (accept) begin
            // Address qualifiers move only here, never alongside a weight beat.
            config_layer_num  <= {24'd0, s_data[31:24]};
            config_neuron_num <= {24'd0, s_data[23:16]};
            remaining         <= s_data[cntWidth-1:0];
            if (hdr_bad(s_data[cntWidth-1:0])) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= WGT;
            end
          end
        end
        WGT: begin
          if (accept) begin
            weightValid <= 1'b1;
            weightValue <= s_data;
            remaining   <= remaining - 1'b1;
            if (remaining == cntWidth'(1)) begin
`ifdef BIAS_LOAD_EN
              state <= BIAS;
`else
              state <= BLKEND;
`endif
            end
          end
        end
`ifdef BIAS_LOAD_EN
        BIAS: begin
          if (accept) begin
            biasValid <= 1'b1;
            biasValue <= s_data;
            state     <= BLKEND;
          end
        end
`endif
        BLKEND: begin
          neurons_loaded <= neurons_loaded + 16'd1;
          if ((neurons_loaded + 16'd1) == total_lat) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= HDR;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef BIAS_LOAD_EN
  // Without bias loading the neurons keep their hard-coded bias constants.
  assign biasValid = 1'b0;
  assign biasValue = '0;
`endif

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader; covers both BIAS_LOAD_EN builds.
module tb_weight_stream_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] total_neurons = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        weightValid;
  logic [31:0] weightValue;
  logic        biasValid;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] neurons_loaded;

  weight_stream_loader dut (
    .clk(clk), .rst(rst), .start(start), .total_neurons(total_neurons),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .weightValid(weightValid), .weightValue(weightValue),
    .biasValid(biasValid), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .busy(busy), .done(done), .err(err), .neurons_loaded(neurons_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [31:0] wv_q[$];
  logic [31:0] wl_q[$];
  logic [31:0] wn_q[$];
  int          wc_q[$];
  logic [31:0] bv_q[$];
  int          bias_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          overlap = 0;

  always @(posedge clk) cyc++;

  // Bus monitor: records every beat with the address qualifiers seen alongside it.
  always @(negedge clk) begin
    if (weightValid) begin
      wv_q.push_back(weightValue);
      wl_q.push_back(config_layer_num);
      wn_q.push_back(config_neuron_num);
      wc_q.push_back(cyc);
    end
    if (biasValid) begin
      bv_q.push_back(biasValue);
      bias_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (weightValid && biasValid) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wv_q.delete(); wl_q.delete(); wn_q.delete(); wc_q.delete(); bv_q.delete();
    done_cnt = 0;
    overlap  = 0;
  endtask

  task automatic do_start(input logic [15:0] n);
    @(posedge clk) #1;
    start = 1'b1;
    total_neurons = n;
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w[$], input bit thr);
    int idx = 0;
    int t = 0;
    while (idx < w.size() && t < 400) begin
      @(posedge clk) #1;
      t++;
      if (!thr || (t % 2 == 0)) begin
        s_valid = 1'b1;
        s_data  = w[idx];
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      if (s_valid && s_ready) begin
        idx++;
        last_acc = cyc;
      end
    end
    @(posedge clk) #1;
    s_valid = 1'b0;
    check("stream_all_accepted", idx, w.size());
  endtask

  task automatic settle();
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_w(input string tag, input logic [31:0] ev[$],
                       input logic [31:0] el[$], input logic [31:0] en[$]);
    check({tag, "_wcount"}, wv_q.size(), ev.size());
    for (int i = 0; i < ev.size() && i < wv_q.size(); i++) begin
      check($sformatf("%s_wval%0d", tag, i), wv_q[i], ev[i]);
      check($sformatf("%s_layer%0d", tag, i), wl_q[i], el[i]);
      check($sformatf("%s_neuron%0d", tag, i), wn_q[i], en[i]);
    end
  endtask

  logic [31:0] words[$];
  logic [31:0] ev[$];
  logic [31:0] el[$];
  logic [31:0] en[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_weightValid", weightValid, 0);
    check("rst_weightValue", weightValue, 0);
    check("rst_biasValid", biasValid, 0);
    check("rst_biasValue", biasValue, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_loaded", neurons_loaded, 0);
    check("rst_layer", config_layer_num, 32'hFFFF_FFFF);
    check("rst_neuron", config_neuron_num, 32'hFFFF_FFFF);
    rst = 1'b0;

    // Basic load, continuous valid
    clr();
    do_start(16'd1);
    @(negedge clk);
    check("basic_busy", busy, 1);
    words = '{32'h0218_0003, 32'd11, 32'd22, 32'd33};
`ifdef BIAS_LOAD_EN
    words.push_back(32'h0000_FE10);
`endif
    send(words, 1'b0);
    settle();
    ev = '{32'd11, 32'd22, 32'd33};
    el = '{32'd2, 32'd2, 32'd2};
    en = '{32'd24, 32'd24, 32'd24};
    chk_w("basic", ev, el, en);
    check("basic_gap01", wc_q[1] - wc_q[0], 1);
    check("basic_gap12", wc_q[2] - wc_q[1], 1);
`ifdef BIAS_LOAD_EN
    check("basic_bcount", bv_q.size(), 1);
    check("basic_bval", bv_q[0], 32'h0000_FE10);
    check("basic_blat", bias_cyc - last_acc, 1);
`else
    check("basic_bcount", bv_q.size(), 0);
    check("basic_wlat", wc_q[2] - last_acc, 1);
`endif
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_lat", done_cyc - last_acc, 2);
    check("basic_loaded", neurons_loaded, 1);
    check("basic_busy_end", busy, 0);
    check("basic_layer", config_layer_num, 2);
    check("basic_neuron", config_neuron_num, 24);
    check("basic_overlap", overlap, 0);

    // Throttled stream
    clr();
    do_start(16'd1);
    send(words, 1'b1);
    settle();
    chk_w("thr", ev, el, en);
    check("thr_gap01", wc_q[1] - wc_q[0], 2);
    check("thr_gap12", wc_q[2] - wc_q[1], 2);
    check("thr_done_cnt", done_cnt, 1);
    check("thr_loaded", neurons_loaded, 1);

    // Multi-neuron session
    clr();
    do_start(16'd3);
    words.delete(); ev.delete(); el.delete(); en.delete();
    for (int i = 0; i < 3; i++) begin
      words.push_back(32'h0100_0002 | (32'(i) << 16));
      words.push_back(32'(100 + 2 * i));
      words.push_back(32'(101 + 2 * i));
`ifdef BIAS_LOAD_EN
      words.push_back(32'(8'hB0 + i));
`endif
      ev.push_back(32'(100 + 2 * i)); el.push_back(32'd1); en.push_back(32'(i));
      ev.push_back(32'(101 + 2 * i)); el.push_back(32'd1); en.push_back(32'(i));
    end
    send(words, 1'b0);
    settle();
    chk_w("multi", ev, el, en);
`ifdef BIAS_LOAD_EN
    check("multi_bcount", bv_q.size(), 3);
    check("multi_bval2", bv_q[2], 32'h0000_00B2);
`else
    check("multi_bcount", bv_q.size(), 0);
`endif
    check("multi_done_cnt", done_cnt, 1);
    check("multi_loaded", neurons_loaded, 3);
    check("multi_neuron_end", config_neuron_num, 2);
    check("multi_overlap", overlap, 0);

    // Empty session completes at once
    clr();
    do_start(16'd0);
    settle();
    check("empty_done_cnt", done_cnt, 1);
    check("empty_busy", busy, 0);

    // Header error: N = 0
    clr();
    do_start(16'd1);
    words = '{32'h0305_0000};
    send(words, 1'b0);
    settle();
    check("err0_err", err, 1);
    check("err0_busy", busy, 0);
    check("err0_wcount", wv_q.size(), 0);
    check("err0_done", done_cnt, 0);

    // Header error: N = maxWeight + 1; start clears the sticky flag first
    clr();
    do_start(16'd1);
    @(negedge clk);
    check("err_cleared", err, 0);
    words = '{32'h0305_0311};
    send(words, 1'b0);
    settle();
    check("errmax_err", err, 1);
    check("errmax_busy", busy, 0);
    check("errmax_wcount", wv_q.size(), 0);
    check("errmax_done", done_cnt, 0);

    // Reset mid-WGT after 2 of 5 weights
    clr();
    do_start(16'd1);
    words = '{32'h0407_0005, 32'd1, 32'd2};
    send(words, 1'b0);
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_wcount", wv_q.size(), 2);
    check("midrst_weightValid", weightValid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_layer", config_layer_num, 32'hFFFF_FFFF);
    check("midrst_neuron", config_neuron_num, 32'hFFFF_FFFF);

    // Full session after the mid-session reset
    clr();
    do_start(16'd1);
    words = '{32'h0218_0003, 32'd11, 32'd22, 32'd33};
`ifdef BIAS_LOAD_EN
    words.push_back(32'h0000_FE10);
`endif
    send(words, 1'b0);
    settle();
    ev = '{32'd11, 32'd22, 32'd33};
    el = '{32'd2, 32'd2, 32'd2};
    en = '{32'd24, 32'd24, 32'd24};
    chk_w("after_rst", ev, el, en);
    check("after_rst_done", done_cnt, 1);
    check("after_rst_loaded", neurons_loaded, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
